// File: rtl/program_loader_pkg.sv
// Shared types for the stream-to-RAM program loader: FSM state encoding.
`default_nettype none
package program_loader_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } loader_state_t;
endpackage
`default_nettype wire

// File: rtl/program_loader_load_addr_counter.sv
// RAM write-address counter with synchronous clear, increment and terminal count.
`default_nettype none
module load_addr_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             tc
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc)
      count <= count + 1'b1;
  end

  assign tc = &count;
endmodule
`default_nettype wire

// File: rtl/program_loader.sv
// Loads a byte stream into RAM from address 0 while holding the CPU in reset.
// Optional macro LOADER_CHECKSUM_EN enables the additive checksum of loaded bytes.
`default_nettype none
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              full,
  output logic [DATA_W-1:0] checksum
);
  loader_state_t state, state_next;
  logic              accept;
  logic              load_start;
  logic [ADDR_W-1:0] addr_count;
  logic              addr_tc;

  load_addr_counter #(.WIDTH(ADDR_W)) u_addr (
    .clk   (clk),
    .reset (reset),
    .clear (load_start),
    .inc   (accept),
    .count (addr_count),
    .tc    (addr_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    in_ready   = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = LOAD;
          load_start = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && (in_last || addr_tc))
          state_next = FLUSH;
      end
      FLUSH: state_next = DONE;
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        // Start in DONE is a reload.
        if (start) begin
          state_next = LOAD;
          load_start = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // Write port is registered: the strobe follows acceptance by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      full     <= 1'b0;
    end else begin
      mem_we <= accept;
      if (accept) begin
        mem_addr <= addr_count;
        mem_data <= in_data;
      end
      if (load_start)
        full <= 1'b0;
      else if (accept && addr_tc && !in_last)
        full <= 1'b1;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      checksum <= '0;
    else if (load_start)
      checksum <= '0;
    else if (accept)
      checksum <= checksum + in_data;
  end
`else
  assign checksum = '0;
`endif
endmodule
`default_nettype wire
